// File: rtl/blocky_pkg.sv
// Shared types and constants for the Blocky move/draw sequencer.
// Optional build macro used by the top: BLOCKY_WRAP_EN (edge wrap instead of clamp).
package blocky_pkg;

  localparam int SCR_W   = 160;
  localparam int SCR_H   = 120;
  localparam int SQ_SIZE = 4;
  localparam int STEP    = 1;
  localparam int X0      = 78;
  localparam int Y0      = 58;

  localparam logic [2:0] SQ_COLOUR = 3'b111;
  localparam logic [2:0] BG_COLOUR = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_DRAW,
    S_WAIT,
    S_ERASE,
    S_UPDATE
  } state_t;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  // Key priority W > S > A > D.
  function automatic dir_t pick_dir(input logic w, input logic s, input logic a, input logic d);
    if (w)      return DIR_UP;
    else if (s) return DIR_DOWN;
    else if (a) return DIR_LEFT;
    else if (d) return DIR_RIGHT;
    else        return DIR_NONE;
  endfunction

endpackage

// File: rtl/blocky_rect_scan.sv
// Rectangle raster scanner: x inner, y outer, one pixel per clock, shared by clear/draw/erase.
// A load while a scan is running restarts it at the new origin on the next cycle.
module blocky_rect_scan (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_org_x,
  input  logic [6:0] i_org_y,
  input  logic [7:0] i_width,
  input  logic [6:0] i_height,
  output logic [7:0] o_x,
  output logic [6:0] o_y,
  output logic       o_valid,
  output logic       o_last
);

  logic [7:0] r_x;
  logic [6:0] r_y;
  logic       r_valid;
  logic [7:0] r_x0;
  logic [7:0] r_x_end;
  logic [6:0] r_y_end;
  logic       w_x_end;
  logic       w_y_end;

  assign w_x_end = (r_x == r_x_end);
  assign w_y_end = (r_y == r_y_end);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_x0    <= '0;
      r_x_end <= '0;
      r_y_end <= '0;
    end else if (i_load) begin
      r_x     <= i_org_x;
      r_y     <= i_org_y;
      r_x0    <= i_org_x;
      r_x_end <= i_org_x + i_width - 8'd1;
      r_y_end <= i_org_y + i_height - 7'd1;
      r_valid <= 1'b1;
    end else if (r_valid) begin
      if (w_x_end) begin
        r_x <= r_x0;
        if (w_y_end) r_valid <= 1'b0;
        else         r_y     <= r_y + 7'd1;
      end else begin
        r_x <= r_x + 8'd1;
      end
    end
  end

  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_valid = r_valid;
  assign o_last  = r_valid && w_x_end && w_y_end;

endmodule

// File: rtl/blocky_move_draw_ctrl.sv
// Blocky sequencer: clear screen, draw square, paced erase/move/redraw, one pixel write per clock.
// Define BLOCKY_WRAP_EN to wrap the square around screen edges instead of clamping it.
module blocky_move_draw_ctrl
  import blocky_pkg::*;
(
  input  logic       clk,
  input  logic       restart,
  input  logic       start,
  input  logic       w_key,
  input  logic       s_key,
  input  logic       a_key,
  input  logic       d_key,
  input  logic       frame_tick,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic [7:0] pos_x,
  output logic [6:0] pos_y,
  output logic       busy
);

  localparam logic [8:0] XMAX9 = 9'(SCR_W - SQ_SIZE);
  localparam logic [7:0] XMAX8 = 8'(SCR_W - SQ_SIZE);
  localparam logic [7:0] YMAX8 = 8'(SCR_H - SQ_SIZE);
  localparam logic [6:0] YMAX7 = 7'(SCR_H - SQ_SIZE);

  state_t     r_state;
  logic [7:0] r_pos_x;
  logic [6:0] r_pos_y;
  logic [7:0] r_tgt_x;
  logic [6:0] r_tgt_y;
  logic [2:0] r_colour;
  logic       r_busy;

  logic       w_load;
  logic [7:0] w_org_x;
  logic [6:0] w_org_y;
  logic [7:0] w_wid;
  logic [6:0] w_hgt;
  logic       w_scan_last;

  dir_t       w_dir;
  logic [8:0] w_dec_x;
  logic [8:0] w_inc_x;
  logic [7:0] w_dec_y;
  logic [7:0] w_inc_y;
  logic [7:0] w_tgt_x;
  logic [6:0] w_tgt_y;
  logic       w_step;

  assign w_dir   = pick_dir(w_key, s_key, a_key, d_key);
  // Widened by one bit so a borrow or overshoot is visible before the edge compare.
  assign w_dec_x = {1'b0, r_pos_x} - 9'(STEP);
  assign w_inc_x = {1'b0, r_pos_x} + 9'(STEP);
  assign w_dec_y = {1'b0, r_pos_y} - 8'(STEP);
  assign w_inc_y = {1'b0, r_pos_y} + 8'(STEP);

  always_comb begin
    w_tgt_x = r_pos_x;
    w_tgt_y = r_pos_y;
    case (w_dir)
`ifdef BLOCKY_WRAP_EN
      DIR_UP:    w_tgt_y = w_dec_y[7] ? YMAX7 : w_dec_y[6:0];
      DIR_DOWN:  w_tgt_y = (w_inc_y > YMAX8) ? 7'd0 : w_inc_y[6:0];
      DIR_LEFT:  w_tgt_x = w_dec_x[8] ? XMAX8 : w_dec_x[7:0];
      DIR_RIGHT: w_tgt_x = (w_inc_x > XMAX9) ? 8'd0 : w_inc_x[7:0];
`else
      DIR_UP:    w_tgt_y = w_dec_y[7] ? 7'd0 : w_dec_y[6:0];
      DIR_DOWN:  w_tgt_y = (w_inc_y > YMAX8) ? YMAX7 : w_inc_y[6:0];
      DIR_LEFT:  w_tgt_x = w_dec_x[8] ? 8'd0 : w_dec_x[7:0];
      DIR_RIGHT: w_tgt_x = (w_inc_x > XMAX9) ? XMAX8 : w_inc_x[7:0];
`endif
      default: ;
    endcase
  end

  assign w_step = frame_tick && (w_dir != DIR_NONE) &&
                  ((w_tgt_x != r_pos_x) || (w_tgt_y != r_pos_y));

  always_comb begin
    w_load  = 1'b0;
    w_org_x = r_pos_x;
    w_org_y = r_pos_y;
    w_wid   = 8'(SQ_SIZE);
    w_hgt   = 7'(SQ_SIZE);
    case (r_state)
      S_IDLE: begin
        w_load  = start;
        w_org_x = 8'd0;
        w_org_y = 7'd0;
        w_wid   = 8'(SCR_W);
        w_hgt   = 7'(SCR_H);
      end
      S_CLEAR:  w_load = w_scan_last;
      S_WAIT:   w_load = w_step;
      S_UPDATE: begin
        w_load  = 1'b1;
        w_org_x = r_tgt_x;
        w_org_y = r_tgt_y;
      end
      default: ;
    endcase
  end

  // The scanner's registers are the pixel outputs, so x/y/plot and colour move on the same edge.
  blocky_rect_scan u_scan (
    .clk      (clk),
    .rst      (restart),
    .i_load   (w_load),
    .i_org_x  (w_org_x),
    .i_org_y  (w_org_y),
    .i_width  (w_wid),
    .i_height (w_hgt),
    .o_x      (vga_x),
    .o_y      (vga_y),
    .o_valid  (vga_plot),
    .o_last   (w_scan_last)
  );

  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      r_state  <= S_IDLE;
      r_pos_x  <= 8'(X0);
      r_pos_y  <= 7'(Y0);
      r_tgt_x  <= 8'(X0);
      r_tgt_y  <= 7'(Y0);
      r_colour <= 3'b000;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_state  <= S_CLEAR;
          r_colour <= BG_COLOUR;
          r_busy   <= 1'b1;
        end
        S_CLEAR: if (w_scan_last) begin
          r_state  <= S_DRAW;
          r_colour <= SQ_COLOUR;
        end
        S_DRAW: if (w_scan_last) begin
          r_state <= S_WAIT;
          r_busy  <= 1'b0;
        end
        S_WAIT: if (w_step) begin
          r_tgt_x  <= w_tgt_x;
          r_tgt_y  <= w_tgt_y;
          r_state  <= S_ERASE;
          r_colour <= BG_COLOUR;
          r_busy   <= 1'b1;
        end
        S_ERASE: if (w_scan_last) r_state <= S_UPDATE;
        S_UPDATE: begin
          r_pos_x  <= r_tgt_x;
          r_pos_y  <= r_tgt_y;
          r_state  <= S_DRAW;
          r_colour <= SQ_COLOUR;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign vga_colour = r_colour;
  assign pos_x      = r_pos_x;
  assign pos_y      = r_pos_y;
  assign busy       = r_busy;

endmodule

// File: tb/tb_blocky_move_draw_ctrl.sv
// Scoreboard bench for blocky_move_draw_ctrl; honours BLOCKY_WRAP_EN for edge expectations.
module tb_blocky_move_draw_ctrl;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  logic       clk = 1'b0;
  logic       restart = 1'b1;
  logic       start = 1'b0;
  logic       w_key = 1'b0;
  logic       s_key = 1'b0;
  logic       a_key = 1'b0;
  logic       d_key = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic [7:0] pos_x;
  logic [6:0] pos_y;
  logic       busy;

  pix_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_x = 78;
  int   m_y = 58;

  blocky_move_draw_ctrl dut (
    .clk        (clk),
    .restart    (restart),
    .start      (start),
    .w_key      (w_key),
    .s_key      (s_key),
    .a_key      (a_key),
    .d_key      (d_key),
    .frame_tick (frame_tick),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Monitor: every plot cycle must match the oldest expected pixel.
  always @(negedge clk) begin
    if (!restart && vga_plot) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        if (n_err < 30)
          $display("FAIL unexpected_plot got x=%0d y=%0d c=%0d, required no plot", vga_x, vga_y, vga_colour);
      end else begin
        pix_t e;
        e = exp_q.pop_front();
        if (vga_x != e.x || vga_y != e.y || vga_colour != e.c) begin
          n_err++;
          if (n_err < 30)
            $display("FAIL pixel got x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                     vga_x, vga_y, vga_colour, e.x, e.y, e.c);
        end
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic push_rect(input int x0, input int y0, input int w, input int h, input int c);
    for (int y = y0; y < y0 + h; y++)
      for (int x = x0; x < x0 + w; x++) begin
        pix_t p;
        p.x = x; p.y = y; p.c = c;
        exp_q.push_back(p);
      end
  endtask

  function automatic void model_tgt(input logic w, input logic s, input logic a, input logic d,
                                    input int px, input int py, output int tx, output int ty);
    tx = px; ty = py;
    if (w) ty = py - 1;
    else if (s) ty = py + 1;
    else if (a) tx = px - 1;
    else if (d) tx = px + 1;
`ifdef BLOCKY_WRAP_EN
    if (tx < 0) tx = 156;
    if (tx > 156) tx = 0;
    if (ty < 0) ty = 116;
    if (ty > 116) ty = 0;
`else
    if (tx < 0) tx = 0;
    if (tx > 156) tx = 156;
    if (ty < 0) ty = 0;
    if (ty > 116) ty = 116;
`endif
  endfunction

  task automatic wait_idle(input string nm, input int limit);
    int n = 0;
    repeat (3) @(posedge clk);
    while ((exp_q.size() != 0 || busy) && n < limit) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check({nm, "_timeout"}, (n >= limit) ? 1 : 0, 0);
    check({nm, "_busy_low"}, busy, 0);
  endtask

  task automatic tick_pulse();
    @(posedge clk); #1;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
  endtask

  task automatic set_keys(input logic w, input logic s, input logic a, input logic d);
    w_key = w; s_key = s; a_key = a; d_key = d;
  endtask

  task automatic step(input logic w, input logic s, input logic a, input logic d,
                      input string nm, input bit verbose);
    int tx, ty;
    model_tgt(w, s, a, d, m_x, m_y, tx, ty);
    if (tx != m_x || ty != m_y) begin
      push_rect(m_x, m_y, 4, 4, 0);
      push_rect(tx, ty, 4, 4, 7);
    end
    set_keys(w, s, a, d);
    tick_pulse();
    set_keys(0, 0, 0, 0);
    wait_idle(nm, 200);
    check({nm, "_pos_x"}, pos_x, tx);
    check({nm, "_pos_y"}, pos_y, ty);
    m_x = tx; m_y = ty;
    if (verbose) $display("step %s: pos (%0d,%0d)", nm, pos_x, pos_y);
  endtask

  task automatic do_start(input string nm);
    push_rect(0, 0, 160, 120, 0);
    push_rect(78, 58, 4, 4, 7);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(nm, 25000);
    m_x = 78; m_y = 58;
    $display("start %s: clear+draw done, pos (%0d,%0d)", nm, pos_x, pos_y);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_plot", vga_plot, 0);
    check("rst_x", vga_x, 0);
    check("rst_y", vga_y, 0);
    check("rst_colour", vga_colour, 0);
    check("rst_busy", busy, 0);
    check("rst_pos_x", pos_x, 78);
    check("rst_pos_y", pos_y, 58);
    @(posedge clk); #1;
    restart = 1'b0;

    // Keys and ticks in S_IDLE do nothing
    set_keys(0, 0, 0, 1);
    tick_pulse();
    set_keys(0, 0, 0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("idle_pos_x", pos_x, 78);
    check("idle_busy", busy, 0);

    do_start("t1");
    check("t1_pos_x", pos_x, 78);

    step(0, 0, 0, 1, "t2_right", 1);
    check("t2_x_lit", pos_x, 79);
    check("t2_y_lit", pos_y, 58);

    step(1, 0, 0, 1, "t3_w_wins", 1);
    check("t3_x_lit", pos_x, 79);
    check("t3_y_lit", pos_y, 57);

    // Second tick during the erase is dropped
    push_rect(79, 57, 4, 4, 0);
    push_rect(80, 57, 4, 4, 7);
    set_keys(0, 0, 0, 1);
    tick_pulse();
    repeat (4) @(posedge clk);
    tick_pulse();
    wait_idle("t6", 200);
    repeat (40) @(posedge clk);
    set_keys(0, 0, 0, 0);
    @(negedge clk);
    check("t6_pos_x", pos_x, 80);
    check("t6_queue_empty", exp_q.size(), 0);
    m_x = 80;
    $display("step t6: pos (%0d,%0d)", pos_x, pos_y);

    while (m_x < 156) step(0, 0, 0, 1, "t4_walk", 0);
    check("t4_at_edge", pos_x, 156);
    step(0, 0, 0, 1, "t4_edge", 1);
`ifdef BLOCKY_WRAP_EN
    check("t4_edge_lit", pos_x, 0);
`else
    check("t4_edge_lit", pos_x, 156);
`endif

    while (m_y > 0) step(1, 0, 0, 0, "up_walk", 0);
    step(1, 0, 0, 0, "up_edge", 1);
`ifdef BLOCKY_WRAP_EN
    check("up_edge_lit", pos_y, 116);
`else
    check("up_edge_lit", pos_y, 0);
`endif

    // Restart mid-draw
    begin
      int tx, ty;
      model_tgt(0, 0, 1, 0, m_x, m_y, tx, ty);
      push_rect(m_x, m_y, 4, 4, 0);
      push_rect(tx, ty, 4, 4, 7);
      set_keys(0, 0, 1, 0);
      tick_pulse();
      set_keys(0, 0, 0, 0);
      repeat (19) @(posedge clk);
      #1;
      restart = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("t5_plot", vga_plot, 0);
      check("t5_busy", busy, 0);
      check("t5_pos_x", pos_x, 78);
      check("t5_pos_y", pos_y, 58);
      @(posedge clk); #1;
      restart = 1'b0;
      set_keys(0, 0, 0, 1);
      tick_pulse();
      repeat (5) @(posedge clk);
      set_keys(0, 0, 0, 0);
      @(negedge clk);
      check("t5_ignored_pos_x", pos_x, 78);
      check("t5_ignored_busy", busy, 0);
      $display("restart t5: pos (%0d,%0d)", pos_x, pos_y);
    end

    do_start("t5_restart");
    step(0, 0, 0, 1, "t5_after", 1);
    check("t5_after_lit", pos_x, 79);

    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
